// File: rtl/vga_scanout.sv
// VGA raster scan-out: generates raster timing, issues pixel coordinates to the
// compositor, and registers the returned colour plus delayed sync/blank onto the
// DAC pins so that colour and sync stay aligned across the pixel-path latency.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [7:0]  i_R,
    input  logic [7:0]  i_G,
    input  logic [7:0]  i_B,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_req,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_VGA_R,
    output logic [7:0]  o_VGA_G,
    output logic [7:0]  o_VGA_B,
    output logic        o_VGA_HS,
    output logic        o_VGA_VS,
    output logic        o_VGA_BLANK_N,
    output logic        o_VGA_SYNC_N
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  h;
    logic [9:0]  v;
    logic [15:0] frame_cnt;

    // Raster counters; disabling parks the raster at the origin and abandons the frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h         <= '0;
            v         <= '0;
            frame_cnt <= '0;
        end else if (!i_en) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
                v         <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                v <= v + 10'd1;
            end
        end else begin
            h <= h + 10'd1;
        end
    end

    assign o_x           = h;
    assign o_y           = v;
    assign o_frame_cnt   = frame_cnt;
    assign o_req         = i_rst_n && i_en && (h < H_ACT) && (v < V_ACT);
    assign o_frame_start = i_rst_n && i_en && (h == 10'd0) && (v == 10'd0);
    assign o_VGA_SYNC_N  = 1'b0;

    // ---- stage 0: controls derived from the current counter state ----
    logic act_p0;
    logic hs_n_p0;
    logic vs_n_p0;
    logic act_d;
    logic hs_n_d;
    logic vs_n_d;

    assign act_p0  = o_req;
    assign hs_n_p0 = !(i_en && (h >= HS_FIRST) && (h <= HS_LAST));
    assign vs_n_p0 = !(i_en && (v >= VS_FIRST) && (v <= VS_LAST));

    // ---- stages 1..PIPE_LAT: controls wait for the compositor's colour ----
    generate
        if (PIPE_LAT == 0) begin : g_bypass
            assign act_d  = act_p0;
            assign hs_n_d = hs_n_p0;
            assign vs_n_d = vs_n_p0;
        end else begin : g_delay
            logic [PIPE_LAT-1:0] act_sr;
            logic [PIPE_LAT-1:0] hs_sr;
            logic [PIPE_LAT-1:0] vs_sr;

            // Shift register carrying active/sync flags alongside the pixel path.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    act_sr <= '0;
                    hs_sr  <= '1;
                    vs_sr  <= '1;
                end else begin
                    act_sr[0] <= act_p0;
                    hs_sr[0]  <= hs_n_p0;
                    vs_sr[0]  <= vs_n_p0;
                    for (int k = 1; k < PIPE_LAT; k++) begin
                        act_sr[k] <= act_sr[k-1];
                        hs_sr[k]  <= hs_sr[k-1];
                        vs_sr[k]  <= vs_sr[k-1];
                    end
                end
            end

            assign act_d  = act_sr[PIPE_LAT-1];
            assign hs_n_d = hs_sr[PIPE_LAT-1];
            assign vs_n_d = vs_sr[PIPE_LAT-1];
        end
    endgenerate

    // ---- output register: colour gated by the aligned active flag ----
    // Pin register; colour is forced to black whenever the aligned pixel is not active.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_VGA_R       <= '0;
            o_VGA_G       <= '0;
            o_VGA_B       <= '0;
            o_VGA_HS      <= 1'b1;
            o_VGA_VS      <= 1'b1;
            o_VGA_BLANK_N <= 1'b0;
        end else begin
            o_VGA_R       <= act_d ? i_R : 8'd0;
            o_VGA_G       <= act_d ? i_G : 8'd0;
            o_VGA_B       <= act_d ? i_B : 8'd0;
            o_VGA_HS      <= hs_n_d;
            o_VGA_VS      <= vs_n_d;
            o_VGA_BLANK_N <= act_d;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: five instances share clock, reset and enable.
// [0] default timing, PIPE_LAT=1   [1] PIPE_LAT=2   [2] PIPE_LAT=0   [3] PIPE_LAT=4
// [4] reduced raster (16x8 total, 8x4 active), PIPE_LAT=1, for frame-level timing.
// Each instance gets a compositor model returning {x, y, x^0x55} after its latency.
module tb_vga_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en;

    logic [9:0]  x   [5];
    logic [9:0]  y   [5];
    logic        req [5];
    logic        fs  [5];
    logic [15:0] fc  [5];
    logic [7:0]  vr  [5];
    logic [7:0]  vg  [5];
    logic [7:0]  vb  [5];
    logic        hs  [5];
    logic        vs  [5];
    logic        bl  [5];
    logic        sy  [5];
    logic [23:0] w      [5];
    logic [23:0] rgb_in [5];

    // compositor models
    logic [23:0] dm, d2a, d2b, d4a, d4b, d4c, d4d, ds;

    always_comb begin
        for (int i = 0; i < 5; i++)
            w[i] = {x[i][7:0], y[i][7:0], x[i][7:0] ^ 8'h55};
    end

    always @(posedge clk) begin
        dm  <= w[0];
        d2a <= w[1];
        d2b <= d2a;
        d4a <= w[3];
        d4b <= d4a;
        d4c <= d4b;
        d4d <= d4c;
        ds  <= w[4];
    end

    assign rgb_in[0] = dm;
    assign rgb_in[1] = d2b;
    assign rgb_in[2] = w[2];
    assign rgb_in[3] = d4d;
    assign rgb_in[4] = ds;

    vga_scanout #(.PIPE_LAT(1)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_R(rgb_in[0][23:16]), .i_G(rgb_in[0][15:8]), .i_B(rgb_in[0][7:0]),
        .o_x(x[0]), .o_y(y[0]), .o_req(req[0]), .o_frame_start(fs[0]), .o_frame_cnt(fc[0]),
        .o_VGA_R(vr[0]), .o_VGA_G(vg[0]), .o_VGA_B(vb[0]), .o_VGA_HS(hs[0]), .o_VGA_VS(vs[0]),
        .o_VGA_BLANK_N(bl[0]), .o_VGA_SYNC_N(sy[0]));

    vga_scanout #(.PIPE_LAT(2)) u_lat2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_R(rgb_in[1][23:16]), .i_G(rgb_in[1][15:8]), .i_B(rgb_in[1][7:0]),
        .o_x(x[1]), .o_y(y[1]), .o_req(req[1]), .o_frame_start(fs[1]), .o_frame_cnt(fc[1]),
        .o_VGA_R(vr[1]), .o_VGA_G(vg[1]), .o_VGA_B(vb[1]), .o_VGA_HS(hs[1]), .o_VGA_VS(vs[1]),
        .o_VGA_BLANK_N(bl[1]), .o_VGA_SYNC_N(sy[1]));

    vga_scanout #(.PIPE_LAT(0)) u_lat0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_R(rgb_in[2][23:16]), .i_G(rgb_in[2][15:8]), .i_B(rgb_in[2][7:0]),
        .o_x(x[2]), .o_y(y[2]), .o_req(req[2]), .o_frame_start(fs[2]), .o_frame_cnt(fc[2]),
        .o_VGA_R(vr[2]), .o_VGA_G(vg[2]), .o_VGA_B(vb[2]), .o_VGA_HS(hs[2]), .o_VGA_VS(vs[2]),
        .o_VGA_BLANK_N(bl[2]), .o_VGA_SYNC_N(sy[2]));

    vga_scanout #(.PIPE_LAT(4)) u_lat4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_R(rgb_in[3][23:16]), .i_G(rgb_in[3][15:8]), .i_B(rgb_in[3][7:0]),
        .o_x(x[3]), .o_y(y[3]), .o_req(req[3]), .o_frame_start(fs[3]), .o_frame_cnt(fc[3]),
        .o_VGA_R(vr[3]), .o_VGA_G(vg[3]), .o_VGA_B(vb[3]), .o_VGA_HS(hs[3]), .o_VGA_VS(vs[3]),
        .o_VGA_BLANK_N(bl[3]), .o_VGA_SYNC_N(sy[3]));

    vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(1)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_R(rgb_in[4][23:16]), .i_G(rgb_in[4][15:8]), .i_B(rgb_in[4][7:0]),
        .o_x(x[4]), .o_y(y[4]), .o_req(req[4]), .o_frame_start(fs[4]), .o_frame_cnt(fc[4]),
        .o_VGA_R(vr[4]), .o_VGA_G(vg[4]), .o_VGA_B(vb[4]), .o_VGA_HS(hs[4]), .o_VGA_VS(vs[4]),
        .o_VGA_BLANK_N(bl[4]), .o_VGA_SYNC_N(sy[4]));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] pins(input int i);
        return {vr[i], vg[i], vb[i], bl[i], hs[i], vs[i]};
    endfunction

    // edge bookkeeping for the scan loop
    int b_rise1 = -1, b_rise2 = -1, b_fall = -1, hs_fall = -1, hs_rise = -1;
    int l2_rise = -1, l2_hs_fall = -1;
    int l0_rise = -1, l4_rise = -1, l0_hs_fall = -1, l4_hs_fall = -1;
    int s_vs_fall = -1, s_vs_rise = -1, s_fs1 = -1, s_fs2 = -1;
    int shift_mism = 0;
    logic pbl, phs, p2bl, p2hs, p0bl, p0hs, p4bl, p4hs, psvs;
    logic [26:0] hist [4];

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();

        // reset values
        check("rst_x",      x[0],  0);
        check("rst_req",    req[0], 0);
        check("rst_fs",     fs[0], 0);
        check("rst_fc",     fc[0], 0);
        check("rst_hs",     hs[0], 1);
        check("rst_vs",     vs[0], 1);
        check("rst_blank",  bl[0], 0);
        check("rst_rgb",    {vr[0], vg[0], vb[0]}, 0);
        check("sync_n",     sy[0], 0);

        rst_n = 1'b1;
        en    = 1'b1;
        #1;
        check("first_fs",  fs[0], 1);
        check("first_req", req[0], 1);

        // reset mid-frame
        repeat (300) step();
        check("pre_rst_x",   x[0], 300);
        check("pre_rst_sx",  x[4], 12);
        check("pre_rst_sy",  y[4], 2);
        check("pre_rst_sfc", fc[4], 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x",     x[0], 0);
        check("mid_rst_req",   req[0], 0);
        check("mid_rst_fs",    fs[0], 0);
        check("mid_rst_sfc",   fc[4], 0);
        check("mid_rst_sy",    y[4], 0);
        check("mid_rst_blank", bl[0], 0);
        check("mid_rst_hsvs",  {hs[0], vs[0]}, 2'b11);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("release_fs", fs[0], 1);

        // scan 1450 cycles from (0,0); sample k shows pins for counter state k-1-PIPE_LAT
        pbl = 1'b0; phs = 1'b1; p2bl = 1'b0; p2hs = 1'b1;
        p0bl = 1'b0; p0hs = 1'b1; p4bl = 1'b0; p4hs = 1'b1; psvs = 1'b1;
        for (int j = 0; j < 4; j++) hist[j] = 27'h3;

        for (int k = 1; k <= 1450; k++) begin
            step();
            if (bl[0] && !pbl) begin
                if (b_rise1 < 0) b_rise1 = k;
                else if (b_rise2 < 0) b_rise2 = k;
            end
            if (!bl[0] && pbl && b_fall < 0) b_fall = k;
            if (!hs[0] && phs && hs_fall < 0) hs_fall = k;
            if (hs[0] && !phs && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
            if (bl[1] && !p2bl && l2_rise < 0) l2_rise = k;
            if (!hs[1] && p2hs && l2_hs_fall < 0) l2_hs_fall = k;
            if (bl[2] && !p0bl && l0_rise < 0) l0_rise = k;
            if (bl[3] && !p4bl && l4_rise < 0) l4_rise = k;
            if (!hs[2] && p0hs && l0_hs_fall < 0) l0_hs_fall = k;
            if (!hs[3] && p4hs && l4_hs_fall < 0) l4_hs_fall = k;
            if (!vs[4] && psvs && s_vs_fall < 0) s_vs_fall = k;
            if (vs[4] && !psvs && s_vs_fall >= 0 && s_vs_rise < 0) s_vs_rise = k;
            if (fs[4]) begin
                if (s_fs1 < 0) s_fs1 = k;
                else if (s_fs2 < 0) s_fs2 = k;
            end
            pbl = bl[0]; phs = hs[0]; p2bl = bl[1]; p2hs = hs[1];
            p0bl = bl[2]; p0hs = hs[2]; p4bl = bl[3]; p4hs = hs[3]; psvs = vs[4];

            if (pins(3) !== hist[3]) shift_mism++;
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pins(2);

            if (k == 2)    check("m_r_px0",    vr[0], 8'h00);
            if (k == 300)  check("m_rgb_px298", {vr[0], vg[0], vb[0]}, 24'h2A007F);
            if (k == 641)  check("m_r_px639",  vr[0], 8'h7F);
            if (k == 700)  check("m_rgb_blank", {vr[0], vg[0], vb[0]}, 0);
            if (k == 1000) check("m_g_line1",  vg[0], 8'h01);
            if (k == 3)    check("l2_px0",     {bl[1], vr[1]}, 9'h100);
            if (k == 642)  check("l2_r_px639", vr[1], 8'h7F);
            if (k == 700)  check("l2_r_blank", vr[1], 8'h00);
            if (k == 127)  check("s_fc_127",   fc[4], 0);
            if (k == 128)  check("s_fc_128",   fc[4], 1);
            if (k == 1280) check("s_fc_1280",  fc[4], 10);
        end

        // line timing at defaults
        check("m_blank_lat",   b_rise1, 2);
        check("m_blank_high",  b_fall - b_rise1, 640);
        check("m_blank_low",   b_rise2 - b_fall, 160);
        check("m_line_period", b_rise2 - b_rise1, 800);
        check("m_hs_offset",   hs_fall - b_fall, 16);
        check("m_hs_width",    hs_rise - hs_fall, 96);
        // PIPE_LAT=2 alignment
        check("l2_blank_lat",  l2_rise, 3);
        check("l2_hs_fall",    l2_hs_fall, 659);
        // PIPE_LAT=0 vs 4
        check("l0_blank_lat",  l0_rise, 1);
        check("l4_blank_lat",  l4_rise, 5);
        check("l0_hs_fall",    l0_hs_fall, 657);
        check("l4_hs_shift",   l4_hs_fall - l0_hs_fall, 4);
        check("l4_vs_l0_mism", shift_mism, 0);
        // frame timing on the reduced raster
        check("s_vs_fall",     s_vs_fall, 82);
        check("s_vs_width",    s_vs_rise - s_vs_fall, 32);
        check("s_fs_first",    s_fs1, 128);
        check("s_fs_period",   s_fs2 - s_fs1, 128);

        // enable drop mid-line at h=100, v=2
        repeat (250) step();
        check("pre_dis_xy", {x[0], y[0]}, {10'd100, 10'd2});
        check("pre_dis_sfc", fc[4], 13);
        en = 1'b0;
        #1;
        check("dis_req", req[0], 0);
        check("dis_fs",  fs[0], 0);
        for (int j = 1; j <= 10; j++) begin
            step();
            if (j == 1) check("dis_xy",        {x[0], y[0]}, 0);
            if (j == 1) check("dis_m_bl_j1",   bl[0], 1);
            if (j == 2) check("dis_m_pins_j2", pins(0), 27'h3);
            if (j == 4) check("dis_l4_bl_j4",  bl[3], 1);
            if (j == 5) check("dis_l4_pins_j5", pins(3), 27'h3);
            if (j == 10) check("dis_hold_xy",  {x[4], y[4]}, 0);
        end
        check("dis_m_fc",  fc[0], 0);
        check("dis_s_fc",  fc[4], 13);
        en = 1'b1;
        #1;
        check("reen_fs_m", fs[0], 1);
        check("reen_fs_s", fs[4], 1);
        repeat (128) step();
        check("reen_s_fc", fc[4], 14);
        check("reen_s_fs", fs[4], 1);
        check("reen_m_xy", {x[0], y[0]}, {10'd128, 10'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
